video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parametrised raster timing generator for the DVI/VGA output path.
- Produces hsync, vsync, data-valid, pixel x/y coordinates and line/frame marker pulses for any resolution, porch set and sync polarity.
- Sits between the pixel-clock domain and the frame-buffer read and encoder logic.
- All outputs are registered, with a fixed one-cycle latency from the internal counters. It supports clock-enable pacing and a synchronous frame restart.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixel clocks)
H_SYNC, 96, hsync pulse width (pixel clocks)
H_BP, 48, horizontal back porch (pixel clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 0, asserted level of vsync (0 = active-low)
X_W, 10, x width; must satisfy 2^X_W >= H_ACTIVE
Y_W, 10, y width; must satisfy 2^Y_W >= V_ACTIVE

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
en  in  1  clock enable; timing advances only when high
restart  in  1  synchronous request to restart the frame at pixel (0,0)
hsync  out  1  horizontal sync, polarity set by HSYNC_POL
vsync  out  1  vertical sync, polarity set by VSYNC_POL
valid_data  out  1  high while the pixel is inside the active area
x  out  X_W  active pixel column; 0 when outside the active area
y  out  Y_W  active line; 0 when in vertical blanking
line_start  out  1  one-cycle pulse on the first active pixel of each active line
frame_start  out  1  one-cycle pulse on pixel (0,0) of each frame
vblank_start  out  1  one-cycle pulse on the first pixel of line V_ACTIVE

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - Internal counter widths are clog2 of each total.
- Line order is active, front porch, sync, back porch. Frame order is the same.
- Counters:
  - h_cnt runs 0..H_TOTAL-1.
  - v_cnt runs 0..V_TOTAL-1 and increments only on an advance where h_cnt == H_TOTAL-1.
  - Both wrap to 0; v_cnt wraps when both counters are at their maximum.
- Advance: each clock edge with en=1, rst=0, restart=0 does two things:
  - Outputs load decode(h_cnt, v_cnt).
  - The counters then step.
  - Outputs therefore lag the counters by exactly 1 cycle.
- decode(h, v):
  - valid_data = (h < H_ACTIVE) & (v < V_ACTIVE).
  - x = h when h < H_ACTIVE, else 0.
  - y = v when v < V_ACTIVE, else 0.
  - hsync = HSYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL.
  - vsync = VSYNC_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~VSYNC_POL. vsync changes only at the line boundary.
  - line_start = (h == 0) & (v < V_ACTIVE).
  - frame_start = (h == 0) & (v == 0).
  - vblank_start = (h == 0) & (v == V_ACTIVE).
- en=0:
  - Counters, hsync, vsync, valid_data, x and y hold their values.
  - line_start, frame_start and vblank_start are forced to 0, so each pulse is emitted once per advance.
- Reset/idle state (rst=1):
  - h_cnt = v_cnt = 0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - valid_data = 0, x = 0, y = 0, all pulses 0.
  - The first advance after reset outputs pixel (0,0) with frame_start = line_start = 1.
- restart=1 (with rst=0):
  - Same effect as rst, regardless of en. This holds mid-line and mid-sync; hsync/vsync deassert immediately.
- Priority: rst > restart > en.
- Wrap: after pixel (H_TOTAL-1, V_TOTAL-1) the next advance outputs (0,0) with frame_start=1. There are no gap cycles.
- Elaboration-time checks: every porch/sync parameter >= 1, H_ACTIVE >= 1, V_ACTIVE >= 1, and the X_W/Y_W bounds above. A violation is a fatal elaboration error.

Decomposition:
- Shared package dvi_timing_pkg holds:
  - the mode constants (640x480@60, 800x600@60, 1280x720@60 porch/sync sets);
  - a clog2 function;
  - the polarity constants.
- One sub-module, wrap_counter, is natural:
  - parameter MAX;
  - ports clk, rst, clr, inc;
  - outputs count and wrap (count==MAX & inc).
  - Instantiate it twice: the horizontal counter's wrap output drives the vertical counter's inc.

Test Plan:
All scenarios use a small mode: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), polarities 0, en=1 constantly after rst is released. Edge k is the k-th edge after release.
1. Reset/first pixel: rst for 3 cycles -> during reset hsync=vsync=1, valid_data=0, x=y=0. At edge 1: valid_data=1, x=0, y=0, frame_start=1, line_start=1.
2. Line timing: run 16 edges -> valid_data high on edges 1-4 and 9-12 with x=0,1,2,3; hsync low only on edges 6,7 and 14,15; line_start on edges 1 and 9.
3. Frame timing: run 96 edges -> vsync low on edges 33-40 and 81-88; vblank_start on edges 25 and 73; frame_start on edges 1 and 49; valid_data never high for edges 25-48.
4. Enable pacing: toggle en 1,0 alternately -> outputs hold during en=0 cycles, pulses are 0 on en=0 cycles, and the sequence equals scenario 3 stretched 2x (frame_start on advances 1 and 49).
5. Restart mid-sync: assert restart at edge 34 (vsync low) -> vsync=1 and valid_data=0 after that edge. The next advance outputs (0,0) with frame_start=1.
6. Reset priority: assert rst and restart together with en=0 -> idle state as in scenario 1. Release both -> the first advance outputs frame_start=1.

Source files
------------

// File: rtl/dvi_timing_pkg.sv
// Shared raster-timing constants for the DVI/VGA output path: standard modes,
// sync polarities and a constant clog2 used to size the timing counters.
package dvi_timing_pkg;

    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        bit          hsync_pol;
        bit          vsync_pol;
    } mode_t;

    localparam mode_t MODE_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33,
        hsync_pol: POL_ACTIVE_LOW, vsync_pol: POL_ACTIVE_LOW
    };

    localparam mode_t MODE_800X600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1, v_sync: 4, v_bp: 23,
        hsync_pol: POL_ACTIVE_HIGH, vsync_pol: POL_ACTIVE_HIGH
    };

    localparam mode_t MODE_1280X720_60 = '{
        h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_active: 720, v_fp: 5, v_sync: 5, v_bp: 20,
        hsync_pol: POL_ACTIVE_HIGH, vsync_pol: POL_ACTIVE_HIGH
    };

    // Ceiling log2, never below 1 so that a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; wrap flags the step that
// returns the count to zero so counters can be chained.
module wrap_counter
    import dvi_timing_pkg::*;
#(
    parameter int unsigned MAX = 7,
    localparam int unsigned W  = clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_L = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = (count_q == MAX_L) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign wrap  = inc && (count_q == MAX_L);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: chained pixel/line counters feed a registered
// decode of sync, data-valid, coordinates and line/frame marker pulses.
module video_timing_gen
    import dvi_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = POL_ACTIVE_LOW,
    parameter bit          VSYNC_POL = POL_ACTIVE_LOW,
    parameter int unsigned X_W       = 10,
    parameter int unsigned Y_W       = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           restart,
    output logic           hsync,
    output logic           vsync,
    output logic           valid_data,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_start,
    output logic           frame_start,
    output logic           vblank_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = clog2(H_TOTAL);
    localparam int unsigned VW      = clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG_L = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END_L = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG_L = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END_L = VW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $fatal(1, "video_timing_gen: every active/porch/sync parameter must be >= 1");
    end
    if ((64'd1 << X_W) < 64'(H_ACTIVE) || (64'd1 << Y_W) < 64'(V_ACTIVE)) begin : g_bad_width
        $fatal(1, "video_timing_gen: X_W/Y_W too narrow for the active area");
    end

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          advance;

    // restart outranks en, so a restart edge never also steps the counters.
    assign advance = en && !restart;

    wrap_counter #(.MAX(H_TOTAL - 1)) u_h_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (restart),
        .inc   (advance),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    wrap_counter #(.MAX(V_TOTAL - 1)) u_v_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (restart),
        .inc   (h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    logic           hsync_d, vsync_d, valid_d, line_start_d, frame_start_d, vblank_start_d;
    logic [X_W-1:0] x_d;
    logic [Y_W-1:0] y_d;
    logic           h_act, v_act;

    always_comb begin
        h_act          = (h_cnt < H_ACT_L);
        v_act          = (v_cnt < V_ACT_L);
        valid_d        = h_act && v_act;
        x_d            = h_act ? X_W'(h_cnt) : '0;
        y_d            = v_act ? Y_W'(v_cnt) : '0;
        hsync_d        = (h_cnt >= HS_BEG_L && h_cnt < HS_END_L) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d        = (v_cnt >= VS_BEG_L && v_cnt < VS_END_L) ? VSYNC_POL : ~VSYNC_POL;
        line_start_d   = (h_cnt == '0) && v_act;
        frame_start_d  = (h_cnt == '0) && (v_cnt == '0);
        vblank_start_d = (h_cnt == '0) && (v_cnt == V_ACT_L);
    end

    logic           hsync_q, vsync_q, valid_q, line_start_q, frame_start_q, vblank_start_q;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            hsync_q        <= ~HSYNC_POL;
            vsync_q        <= ~VSYNC_POL;
            valid_q        <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else if (en) begin
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            valid_q        <= valid_d;
            x_q            <= x_d;
            y_q            <= y_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
        end else begin
            // Level outputs hold; pulses drop so each marks exactly one advance.
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign valid_data   = valid_q;
    assign x            = x_q;
    assign y            = y_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;

    frame_wrap_at_corner: assert property (@(posedge clk) v_wrap |-> h_wrap && (v_cnt == VW'(V_TOTAL - 1)));

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen in a small 8x6 raster mode, against a model that
// derives every output from the number of advances since the last reset/restart.
module tb_video_timing_gen;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int XW = 3, YW = 2;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          vd;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          ls;
        logic          fs;
        logic          vbs;
    } out_t;

    logic          clk = 1'b0;
    logic          rst, en, restart;
    logic          hsync, vsync, valid_data, line_start, frame_start, vblank_start;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    out_t          got;
    out_t          cur;
    int            adv_n;
    int            tests_run = 0;
    int            tests_failed = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .X_W(XW), .Y_W(YW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .restart      (restart),
        .hsync        (hsync),
        .vsync        (vsync),
        .valid_data   (valid_data),
        .x            (x),
        .y            (y),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .vblank_start (vblank_start)
    );

    assign got = {hsync, vsync, valid_data, x, y, line_start, frame_start, vblank_start};

    function automatic out_t idle_exp();
        out_t o;
        o    = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    // Output produced by the n-th advance (0-based) of a frame-aligned raster.
    function automatic out_t decode_exp(input int n);
        out_t o;
        int   h, v;
        h     = n % HT;
        v     = (n / HT) % VT;
        o.vd  = (h < HA) && (v < VA);
        o.x   = (h < HA) ? XW'(h) : '0;
        o.y   = (v < VA) ? YW'(v) : '0;
        o.hs  = !(h >= HA + HF && h < HA + HF + HS);
        o.vs  = !(v >= VA + VF && v < VA + VF + VS);
        o.ls  = (h == 0) && (v < VA);
        o.fs  = (h == 0) && (v == 0);
        o.vbs = (h == 0) && (v == VA);
        return o;
    endfunction

    task automatic tick(input logic e, input logic rs, input logic r);
        en      = e;
        restart = rs;
        rst     = r;
        @(posedge clk);
        #1;
        if (r || rs) begin
            cur   = idle_exp();
            adv_n = 0;
        end else if (e) begin
            cur   = decode_exp(adv_n);
            adv_n = adv_n + 1;
        end else begin
            cur.ls  = 1'b0;
            cur.fs  = 1'b0;
            cur.vbs = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            tests_run++;
            if (got !== {1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 3'b000}) begin
                tests_failed++;
                $display("FAIL reset_idle cycle %0d: got %h required %h", i, got, idle_exp());
            end
        end
        tick(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (!(valid_data === 1'b1 && x === '0 && y === '0 && frame_start === 1'b1 && line_start === 1'b1)) begin
            tests_failed++;
            $display("FAIL first_pixel: got %h required vd=1 x=0 y=0 fs=1 ls=1", got);
        end
    endtask

    task automatic test_line_timing();
        int ls_edges[$];
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            tests_run++;
            if (got !== cur) begin
                tests_failed++;
                $display("FAIL line_timing edge %0d: got %h required %h", k, got, cur);
            end
            if (line_start === 1'b1) ls_edges.push_back(k);
        end
        tests_run++;
        if (ls_edges.size() != 2 || ls_edges[0] != 1 || ls_edges[1] != 9) begin
            tests_failed++;
            $display("FAIL line_start_edges: got %0d pulses (first %0d) required edges 1 and 9",
                     ls_edges.size(), (ls_edges.size() > 0) ? ls_edges[0] : -1);
        end
    endtask

    task automatic test_frame_timing();
        int vd_blank = 0;
        int vs_low = 0;
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 96; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            tests_run++;
            if (got !== cur) begin
                tests_failed++;
                $display("FAIL frame_timing edge %0d: got %h required %h", k, got, cur);
            end
            if (k >= 25 && k <= 48 && valid_data === 1'b1) vd_blank++;
            if (vsync === 1'b0) vs_low++;
        end
        tests_run++;
        if (vd_blank != 0 || vs_low != 16) begin
            tests_failed++;
            $display("FAIL vblank_region: got vd_in_blank=%0d vsync_low=%0d required 0 and 16", vd_blank, vs_low);
        end
    endtask

    task automatic test_enable_pacing();
        int   adv = 0;
        int   fs_adv[$];
        out_t prev;
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 192; i++) begin
            prev = got;
            tick((i % 2) == 0, 1'b0, 1'b0);
            if ((i % 2) == 0) adv++;
            tests_run++;
            if (got !== cur) begin
                tests_failed++;
                $display("FAIL en_pacing cycle %0d: got %h required %h", i, got, cur);
            end
            if ((i % 2) == 1) begin
                tests_run++;
                if (got[10:3] !== prev[10:3] || got[2:0] !== 3'b000) begin
                    tests_failed++;
                    $display("FAIL en_hold cycle %0d: got %h required levels of %h, pulses 0", i, got, prev);
                end
            end
            if (frame_start === 1'b1) fs_adv.push_back(adv);
        end
        tests_run++;
        if (fs_adv.size() != 2 || fs_adv[0] != 1 || fs_adv[1] != 49) begin
            tests_failed++;
            $display("FAIL en_frame_start: got %0d pulses (first at advance %0d) required advances 1 and 49",
                     fs_adv.size(), (fs_adv.size() > 0) ? fs_adv[0] : -1);
        end
    endtask

    task automatic test_restart();
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 33; k++) tick(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (vsync !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_precond: got vsync=%b required 0 at edge 33", vsync);
        end
        tick(1'b1, 1'b1, 1'b0);
        tests_run++;
        if (got !== {1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 3'b000}) begin
            tests_failed++;
            $display("FAIL restart_idle: got %h required %h", got, idle_exp());
        end
        tick(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (!(frame_start === 1'b1 && valid_data === 1'b1 && x === '0 && y === '0)) begin
            tests_failed++;
            $display("FAIL restart_first_pixel: got %h required vd=1 x=0 y=0 fs=1", got);
        end
    endtask

    task automatic test_reset_priority();
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 13; k++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        tests_run++;
        if (got !== {1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 3'b000}) begin
            tests_failed++;
            $display("FAIL rst_restart_idle: got %h required %h", got, idle_exp());
        end
        tick(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (got !== decode_exp(0) || frame_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_release_first: got %h required %h", got, decode_exp(0));
        end
    endtask

    task automatic test_random();
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 199) == 0));
            tests_run++;
            if (got !== cur) begin
                tests_failed++;
                $display("FAIL random cycle %0d: got %h required %h", i, got, cur);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        restart = 1'b0;
        cur     = idle_exp();
        adv_n   = 0;
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_enable_pacing();
        test_restart();
        test_reset_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
